// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: decoder state encoding, block geometry and the
// run_before code table fragments that do not reduce to simple arithmetic.
package cavlc_pkg;

  localparam int MAX_COEFF = 16;
  localparam int WIN_W     = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    FLUSH  = 2'd2
  } rb_state_e;

  // From this zeros_left upward the table uses 3-bit codes then a unary escape.
  localparam logic [3:0] RB_ZL_ESC = 4'd7;

  // zeros_left==6, 3-bit prefix -> run (prefixes 110/111 are the 2-bit code '11').
  localparam logic [31:0] RB_ZL6_RUN = {4'd0, 4'd0, 4'd5, 4'd6, 4'd3, 4'd4, 4'd2, 4'd1};

endpackage

// File: rtl/run_before_lut.sv
// Combinational run_before codeword lookup on an MSB-first window.
// Flags an all-zero escape window and any run exceeding zeros_left as illegal.
module run_before_lut
  import cavlc_pkg::*;
(
  input  logic [WIN_W-1:0] window_i,
  input  logic [3:0]       zeros_left_i,
  output logic [3:0]       run_o,
  output logic [3:0]       len_o,
  output logic             illegal_o
);

  logic found;

  always_comb begin
    run_o     = 4'd0;
    len_o     = 4'd0;
    illegal_o = 1'b0;
    found     = 1'b0;
    case (zeros_left_i)
      4'd0: illegal_o = 1'b1;
      4'd1: begin
        run_o = window_i[10] ? 4'd0 : 4'd1;
        len_o = 4'd1;
      end
      4'd2: begin
        if (window_i[10]) begin
          run_o = 4'd0;
          len_o = 4'd1;
        end else begin
          run_o = window_i[9] ? 4'd1 : 4'd2;
          len_o = 4'd2;
        end
      end
      4'd3: begin
        run_o = 4'd3 - {2'b00, window_i[10:9]};
        len_o = 4'd2;
      end
      4'd4: begin
        if (window_i[10] | window_i[9]) begin
          run_o = 4'd3 - {2'b00, window_i[10:9]};
          len_o = 4'd2;
        end else begin
          run_o = window_i[8] ? 4'd3 : 4'd4;
          len_o = 4'd3;
        end
      end
      4'd5: begin
        if (window_i[10]) begin
          run_o = window_i[9] ? 4'd0 : 4'd1;
          len_o = 4'd2;
        end else begin
          run_o = 4'd5 - {2'b00, window_i[9:8]};
          len_o = 4'd3;
        end
      end
      4'd6: begin
        if (window_i[10:9] == 2'b11) begin
          run_o = 4'd0;
          len_o = 4'd2;
        end else begin
          run_o = RB_ZL6_RUN[{window_i[10:8], 2'b00} +: 4];
          len_o = 4'd3;
        end
      end
      default: begin
        if (window_i[10:8] != 3'b000) begin
          run_o = 4'd7 - {1'b0, window_i[10:8]};
          len_o = 4'd3;
        end else begin
          // Escape: position of the first 1 after the 000 prefix sets the length.
          for (int i = 7; i >= 0; i--) begin
            if (!found && window_i[i]) begin
              found = 1'b1;
              run_o = 4'(14 - i);
              len_o = 4'(11 - i);
            end
          end
          illegal_o = !found;
        end
      end
    endcase
    if (run_o > zeros_left_i) illegal_o = 1'b1;
  end

endmodule

// File: rtl/run_before_decoder.sv
// Emits (run, zig-zag position) per coefficient in reverse order, one per cycle,
// consuming run_before codewords only on a run_valid & run_ready transfer.
module run_before_decoder
  import cavlc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       total_coeff,
  input  logic [3:0]       total_zeros,
  input  logic [WIN_W-1:0] bs_window,
  input  logic             bs_valid,
  output logic             bs_shift_en,
  output logic [3:0]       bs_shift,
  output logic             run_valid,
  input  logic             run_ready,
  output logic [3:0]       run_value,
  output logic [3:0]       coeff_pos,
  output logic             run_last,
  output logic             busy,
  output logic             error
);

  rb_state_e  state_q, state_d;
  logic [4:0] coeff_left_q, coeff_left_d;
  logic [3:0] zeros_left_q, zeros_left_d;
  logic [4:0] pos_q, pos_d;
  logic       error_q, error_d;

  logic [3:0] lut_run, lut_len;
  logic       lut_illegal;
  logic       bad_totals;

  run_before_lut u_lut (
    .window_i     (bs_window),
    .zeros_left_i (zeros_left_q),
    .run_o        (lut_run),
    .len_o        (lut_len),
    .illegal_o    (lut_illegal)
  );

  assign bad_totals = (total_coeff == 5'd0) ||
                      ((6'(total_coeff) + 6'(total_zeros)) > 6'(MAX_COEFF));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      coeff_left_q <= 5'd0;
      zeros_left_q <= 4'd0;
      pos_q        <= 5'd0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      coeff_left_q <= coeff_left_d;
      zeros_left_q <= zeros_left_d;
      pos_q        <= pos_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    coeff_left_d = coeff_left_q;
    zeros_left_d = zeros_left_q;
    pos_d        = pos_q;
    error_d      = error_q;
    bs_shift_en  = 1'b0;
    bs_shift     = 4'd0;
    run_valid    = 1'b0;
    run_value    = 4'd0;
    run_last     = 1'b0;
    coeff_pos    = 4'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = bad_totals;
          if (!bad_totals) begin
            coeff_left_d = total_coeff;
            zeros_left_d = total_zeros;
            pos_d        = total_coeff + 5'(total_zeros) - 5'd1;
            state_d      = (total_zeros == 4'd0 && total_coeff > 5'd1) ? FLUSH : DECODE;
          end
        end
      end
      default: begin
        coeff_pos = pos_q[3:0];
        if (coeff_left_q == 5'd1) begin
          // Last coefficient owns every remaining zero; no codeword is sent for it.
          run_valid = 1'b1;
          run_value = zeros_left_q;
          run_last  = 1'b1;
          if (run_ready) begin
            state_d      = IDLE;
            coeff_left_d = 5'd0;
            zeros_left_d = 4'd0;
            pos_d        = 5'd0;
          end
        end else if (zeros_left_q == 4'd0) begin
          run_valid = 1'b1;
          if (run_ready) begin
            pos_d        = pos_q - 5'd1;
            coeff_left_d = coeff_left_q - 5'd1;
            state_d      = FLUSH;
          end
        end else if (bs_valid) begin
          if (lut_illegal) begin
            error_d      = 1'b1;
            state_d      = IDLE;
            coeff_left_d = 5'd0;
            zeros_left_d = 4'd0;
            pos_d        = 5'd0;
          end else begin
            run_valid = 1'b1;
            run_value = lut_run;
            if (run_ready) begin
              bs_shift_en  = 1'b1;
              bs_shift     = lut_len;
              pos_d        = pos_q - 5'(lut_run) - 5'd1;
              zeros_left_d = zeros_left_q - lut_run;
              coeff_left_d = coeff_left_q - 5'd1;
              state_d      = (zeros_left_d == 4'd0 && coeff_left_d > 5'd1) ? FLUSH : DECODE;
            end
          end
        end
      end
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign error = error_q;

endmodule
